switch_block_dbcfg: RTL and testbench

//  Parametrised successor to the 4-track switch block: W-track Wilton-style routing switch with

---
 rtl/switch_block_dbcfg_pkg.sv | 23 ++
 rtl/switch_block_dbcfg_if.sv | 30 +++
 rtl/sb_track_mux.sv | 21 ++
 rtl/switch_block_dbcfg.sv | 118 +++++++++++
 tb/tb_switch_block_dbcfg.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/switch_block_dbcfg_pkg.sv
// Shared constants for the double-buffered Wilton switch block.
// Select encodings, side ordering and index helpers used at elaboration.
package switch_block_dbcfg_pkg;

  localparam logic [1:0] SEL_STRAIGHT = 2'd0;
  localparam logic [1:0] SEL_TURN_A   = 2'd1;
  localparam logic [1:0] SEL_TURN_B   = 2'd2;
  localparam logic [1:0] SEL_CLB      = 2'd3;

  localparam int SIDE_LEFT   = 0;
  localparam int SIDE_RIGHT  = 1;
  localparam int SIDE_TOP    = 2;
  localparam int SIDE_BOTTOM = 3;

  function automatic int cfg_base(input int side, input int w);
    return side * 2 * w;
  endfunction

  function automatic int wrap(input int idx, input int w);
    return ((idx % w) + w) % w;
  endfunction

endpackage

// File: rtl/switch_block_dbcfg_if.sv
// Track bundle of one switch block: incoming/outgoing tracks per side
// plus the two CLB output pins feeding the block.
interface switch_block_dbcfg_if #(
  parameter int W = 4
);

  logic [W-1:0] left_in;
  logic [W-1:0] right_in;
  logic [W-1:0] top_in;
  logic [W-1:0] bottom_in;
  logic         left_clb_in;
  logic         right_clb_in;
  logic [W-1:0] left_out;
  logic [W-1:0] right_out;
  logic [W-1:0] top_out;
  logic [W-1:0] bottom_out;

  modport master (
    output left_in, right_in, top_in, bottom_in,
    output left_clb_in, right_clb_in,
    input  left_out, right_out, top_out, bottom_out
  );

  modport slave (
    input  left_in, right_in, top_in, bottom_in,
    input  left_clb_in, right_clb_in,
    output left_out, right_out, top_out, bottom_out
  );

endinterface

// File: rtl/sb_track_mux.sv
// One outgoing track: 4:1 source select driven by a 2-bit config field.
// Input order follows the select encoding (straight, turn A, turn B, CLB).
module sb_track_mux
  import switch_block_dbcfg_pkg::*;
(
  input  logic [3:0] in,
  input  logic [1:0] sel,
  output logic       out
);

  always_comb begin
    out = 1'b0;
    unique case (sel)
      SEL_STRAIGHT: out = in[0];
      SEL_TURN_A:   out = in[1];
      SEL_TURN_B:   out = in[2];
      SEL_CLB:      out = in[3];
    endcase
  end

endmodule

// File: rtl/switch_block_dbcfg.sv
// W-track Wilton switch block with a scan shadow chain committed
// atomically into the active routing config; optional output registers.
module switch_block_dbcfg
  import switch_block_dbcfg_pkg::*;
#(
  parameter int CHANNEL_ONEWAY_WIDTH = 4,
  parameter int REG_OUT              = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic scan_en,
  input  logic scan_in,
  output logic scan_out,
  input  logic cfg_load,
  output logic cfg_valid,
  output logic cfg_err,
  switch_block_dbcfg_if.slave sb
);

  localparam int W        = CHANNEL_ONEWAY_WIDTH;
  localparam int CFG_BITS = 8 * W;
  localparam int CW       = $clog2(CFG_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CFG_BITS - 1);

  logic [CFG_BITS-1:0] shadow;
  logic [CFG_BITS-1:0] active;
  logic [CW-1:0]       bit_cnt;

  // Load decisions look at pre-shift shadow and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow    <= '0;
      active    <= '0;
      bit_cnt   <= '0;
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      if (scan_en) begin
        shadow  <= {scan_in, shadow[CFG_BITS-1:1]};
        bit_cnt <= (bit_cnt == CNT_LAST) ? '0 : bit_cnt + CW'(1);
      end
      if (cfg_load) begin
        if (bit_cnt == '0) begin
          active    <= shadow;
          cfg_valid <= 1'b1;
        end else begin
          cfg_err <= 1'b1;
        end
      end
    end
  end

  assign scan_out = shadow[0];

  logic [W-1:0] rt_l;
  logic [W-1:0] rt_r;
  logic [W-1:0] rt_t;
  logic [W-1:0] rt_b;

  for (genvar i = 0; i < W; i++) begin : g_trk
    localparam int NX = wrap(i + 1, W);
    localparam int PV = wrap(i - 1, W);
    localparam int MR = wrap(W - 2 - i, W);
    localparam int SL = cfg_base(SIDE_LEFT, W) + 2 * i;
    localparam int SR = cfg_base(SIDE_RIGHT, W) + 2 * i;
    localparam int ST = cfg_base(SIDE_TOP, W) + 2 * i;
    localparam int SB = cfg_base(SIDE_BOTTOM, W) + 2 * i;

    logic clb_l;
    logic clb_r;

    // Only the outermost track of each side can reach a CLB pin.
    assign clb_l = (i == W - 1) ? sb.left_clb_in : 1'b0;
    assign clb_r = (i == W - 1) ? sb.right_clb_in : 1'b0;

    sb_track_mux u_l (
      .in ({clb_l, sb.bottom_in[MR], sb.top_in[NX], sb.right_in[i]}),
      .sel(active[SL +: 2]),
      .out(rt_l[i])
    );

    sb_track_mux u_r (
      .in ({clb_r, sb.bottom_in[PV], sb.top_in[MR], sb.left_in[i]}),
      .sel(active[SR +: 2]),
      .out(rt_r[i])
    );

    sb_track_mux u_t (
      .in ({1'b0, sb.right_in[MR], sb.left_in[PV], sb.bottom_in[i]}),
      .sel(active[ST +: 2]),
      .out(rt_t[i])
    );

    sb_track_mux u_b (
      .in ({1'b0, sb.right_in[NX], sb.left_in[MR], sb.top_in[i]}),
      .sel(active[SB +: 2]),
      .out(rt_b[i])
    );
  end

  logic [4*W-1:0] gated;

  assign gated = cfg_valid ? {rt_b, rt_t, rt_r, rt_l} : '0;

  if (REG_OUT != 0) begin : g_reg
    logic [4*W-1:0] oreg;

    always_ff @(posedge clk) begin
      if (rst) oreg <= '0;
      else     oreg <= gated;
    end

    assign {sb.bottom_out, sb.top_out, sb.right_out, sb.left_out} = oreg;
  end else begin : g_comb
    assign {sb.bottom_out, sb.top_out, sb.right_out, sb.left_out} = gated;
  end

endmodule

// File: tb/tb_switch_block_dbcfg.sv
// Scoreboard bench: combinational and registered instances driven in
// lockstep and compared against a table-level routing model.
module tb_switch_block_dbcfg;

  localparam int W  = 4;
  localparam int NB = 8 * W;

  typedef struct packed {
    logic [W-1:0] l;
    logic [W-1:0] r;
    logic [W-1:0] t;
    logic [W-1:0] b;
  } outs_t;

  typedef struct packed {
    outs_t o;
    logic  so;
    logic  cv;
    logic  ce;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic scan_en = 1'b0;
  logic scan_in = 1'b0;
  logic cfg_load = 1'b0;
  logic so0, cv0, ce0, so1, cv1, ce1;

  logic [W-1:0] li = '0, ri = '0, ti = '0, bi = '0;
  logic lc = 1'b0, rc = 1'b0;
  logic [W-1:0] nl = '0, nr = '0, nt = '0, nb = '0;
  logic nlc = 1'b0, nrc = 1'b0;

  switch_block_dbcfg_if #(.W(W)) bus0 ();
  switch_block_dbcfg_if #(.W(W)) bus1 ();

  assign bus0.left_in = li;
  assign bus0.right_in = ri;
  assign bus0.top_in = ti;
  assign bus0.bottom_in = bi;
  assign bus0.left_clb_in = lc;
  assign bus0.right_clb_in = rc;
  assign bus1.left_in = li;
  assign bus1.right_in = ri;
  assign bus1.top_in = ti;
  assign bus1.bottom_in = bi;
  assign bus1.left_clb_in = lc;
  assign bus1.right_clb_in = rc;

  switch_block_dbcfg #(.CHANNEL_ONEWAY_WIDTH(W), .REG_OUT(0)) dut0 (
    .clk(clk), .rst(rst), .scan_en(scan_en), .scan_in(scan_in),
    .scan_out(so0), .cfg_load(cfg_load), .cfg_valid(cv0),
    .cfg_err(ce0), .sb(bus0)
  );

  switch_block_dbcfg #(.CHANNEL_ONEWAY_WIDTH(W), .REG_OUT(1)) dut1 (
    .clk(clk), .rst(rst), .scan_en(scan_en), .scan_in(scan_in),
    .scan_out(so1), .cfg_load(cfg_load), .cfg_valid(cv1),
    .cfg_err(ce1), .sb(bus1)
  );

  // Reference model state
  logic [NB-1:0] m_sh = '0;
  logic [NB-1:0] m_act = '0;
  int m_cnt = 0;
  bit m_v = 1'b0;
  bit m_e = 1'b0;

  exp_t q0[$];
  outs_t q1[$];
  int n_chk = 0;
  int n_fail = 0;

  function automatic int md(input int x);
    return ((x % W) + W) % W;
  endfunction

  // Source of one outgoing track, straight from the routing table.
  function automatic logic pick(input int side, input int i,
                                input logic [1:0] sel);
    int a, b, c;
    a = md(i + 1);
    b = md(i - 1);
    c = md(W - 2 - i);
    case (side)
      0: case (sel)
        2'd0: return ri[i];
        2'd1: return ti[a];
        2'd2: return bi[c];
        default: return (i == W - 1) && lc;
      endcase
      1: case (sel)
        2'd0: return li[i];
        2'd1: return ti[c];
        2'd2: return bi[b];
        default: return (i == W - 1) && rc;
      endcase
      2: case (sel)
        2'd0: return bi[i];
        2'd1: return li[b];
        2'd2: return ri[c];
        default: return 1'b0;
      endcase
      default: case (sel)
        2'd0: return ti[i];
        2'd1: return li[c];
        2'd2: return ri[a];
        default: return 1'b0;
      endcase
    endcase
  endfunction

  function automatic outs_t route();
    outs_t o;
    logic [1:0] s;
    o = '0;
    if (m_v) begin
      for (int i = 0; i < W; i++) begin
        s = m_act[0 * 2 * W + 2 * i +: 2];
        o.l[i] = pick(0, i, s);
        s = m_act[1 * 2 * W + 2 * i +: 2];
        o.r[i] = pick(1, i, s);
        s = m_act[2 * 2 * W + 2 * i +: 2];
        o.t[i] = pick(2, i, s);
        s = m_act[3 * 2 * W + 2 * i +: 2];
        o.b[i] = pick(3, i, s);
      end
    end
    return o;
  endfunction

  task automatic tick(input bit r, input bit se, input bit si, input bit ld);
    exp_t e;
    logic [NB-1:0] old_sh;
    int old_cnt;
    @(posedge clk);
    #1;
    rst = r;
    scan_en = se;
    scan_in = si;
    cfg_load = ld;
    li = nl; ri = nr; ti = nt; bi = nb; lc = nlc; rc = nrc;
    e.o = route();
    e.so = m_sh[0];
    e.cv = m_v;
    e.ce = m_e;
    q0.push_back(e);
    q1.push_back(r ? outs_t'(0) : route());
    if (r) begin
      m_sh = '0; m_act = '0; m_cnt = 0; m_v = 0; m_e = 0;
    end else begin
      old_sh = m_sh;
      old_cnt = m_cnt;
      if (se) begin
        m_sh = {si, m_sh[NB-1:1]};
        m_cnt = (m_cnt + 1) % NB;
      end
      if (ld) begin
        if (old_cnt == 0) begin
          m_act = old_sh;
          m_v = 1'b1;
        end else begin
          m_e = 1'b1;
        end
      end
    end
  endtask

  task automatic rnd_traffic();
    nl = W'($urandom); nr = W'($urandom);
    nt = W'($urandom); nb = W'($urandom);
    nlc = 1'($urandom); nrc = 1'($urandom);
  endtask

  task automatic shift_n(input logic [NB-1:0] c, input int from, input int n);
    for (int k = from; k < from + n; k++) begin
      rnd_traffic();
      tick(1'b0, 1'b1, c[k], 1'b0);
    end
  endtask

  task automatic shift_load(input logic [NB-1:0] c);
    shift_n(c, 0, NB);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      rnd_traffic();
      tick(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    outs_t a0, a1, x1;
    if (q0.size() > 0 && q1.size() > 0) begin
      e = q0.pop_front();
      x1 = q1.pop_front();
      a0 = {bus0.left_out, bus0.right_out, bus0.top_out, bus0.bottom_out};
      a1 = {bus1.left_out, bus1.right_out, bus1.top_out, bus1.bottom_out};
      n_chk++;
      if (a0 !== e.o) begin
        n_fail++;
        $display("FAIL comb_outs got %h want %h t=%0t", a0, e.o, $time);
      end
      n_chk++;
      if ({so0, cv0, ce0} !== {e.so, e.cv, e.ce}) begin
        n_fail++;
        $display("FAIL flags0 got %b want %b t=%0t",
                 {so0, cv0, ce0}, {e.so, e.cv, e.ce}, $time);
      end
      n_chk++;
      if (a1 !== x1) begin
        n_fail++;
        $display("FAIL reg_outs got %h want %h t=%0t", a1, x1, $time);
      end
      n_chk++;
      if ({so1, cv1, ce1} !== {e.so, e.cv, e.ce}) begin
        n_fail++;
        $display("FAIL flags1 got %b want %b t=%0t",
                 {so1, cv1, ce1}, {e.so, e.cv, e.ce}, $time);
      end
    end
  end

  initial begin
    logic [NB-1:0] c;
    int pad;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    q1.push_back('0);

    // Unconfigured block drives nothing even with all inputs high.
    nl = '1; nr = '1; nt = '1; nb = '1; nlc = 1'b1; nrc = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 1'b0, 1'b0);

    // Left track 0 turns onto top track 1.
    shift_load(32'h0000_0001);
    nl = '0; nr = '0; nb = '0; nt = 4'b0010; nlc = 1'b0; nrc = 1'b0;
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 1'b0, 1'b0);

    // Misaligned load rejected, then completed load accepted.
    c = 32'hA5C3_1E69;
    shift_n(c, 0, 17);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    shift_n(c, 17, 15);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);

    // CLB pins onto the outermost tracks.
    shift_load(32'h0000_C0FF);
    for (int k = 0; k < 6; k++) begin
      nlc = 1'b1;
      nrc = k[0];
      tick(1'b0, 1'b0, 1'b0, 1'b0);
    end

    // New config shifted under live traffic, straight-through on top.
    shift_load(32'h0000_0000);
    for (int k = 0; k < 6; k++) begin
      nb = {1'b0, k[0], 2'b00};
      tick(1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Reset mid-shift clears the bit counter.
    shift_n(32'hFFFF_FFFF, 0, 10);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    shift_load($urandom);
    idle(3);

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) != 0) begin
        pad = (NB - m_cnt) % NB;
        for (int k = 0; k < pad; k++) begin
          rnd_traffic();
          tick(1'b0, 1'b1, 1'($urandom), 1'b0);
        end
      end
      shift_load($urandom);
      for (int k = 0; k < 15; k++) begin
        rnd_traffic();
        tick($urandom_range(0, 199) == 0,
             $urandom_range(0, 7) == 0,
             1'($urandom),
             $urandom_range(0, 9) == 0);
      end
    end

    idle(2);
    @(posedge clk);
    @(negedge clk);
    #1;
    n_chk++;
    if (q0.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending want 0", q0.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
